// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 message padder: FSM encoding,
// block geometry and padding constants.
package sha256_pkg;

   localparam int         BLOCK_W     = 512;
   localparam int         BLOCK_BYTES = BLOCK_W / 8;
   localparam logic [7:0] PAD_BYTE    = 8'h80;
   localparam int         LEN_OFFSET  = 56;

   typedef enum logic [2:0] {
      ST_FILL   = 3'd0,
      ST_PAD    = 3'd1,
      ST_SEND   = 3'd2,
      ST_WAIT   = 3'd3,
      ST_LENBLK = 3'd4
   } state_t;

endpackage

// File: rtl/sha256_pad_block.sv
// Combinational padding of one block: bytes below idx_i are kept, then the
// optional 0x80 marker, zero fill, and an optional 64-bit big-endian length.
module sha256_pad_block
   import sha256_pkg::*;
(
   input  logic [BLOCK_W-1:0] block_i,
   input  logic [6:0]         idx_i,
   input  logic [63:0]        len_i,
   input  logic               pad_en_i,
   input  logic               len_en_i,
   output logic [BLOCK_W-1:0] block_o
);

   always_comb begin
      block_o = '0;
      for (int k = 0; k < BLOCK_BYTES; k++) begin
         if (7'(k) < idx_i) begin
            block_o[BLOCK_W-1-8*k -: 8] = block_i[BLOCK_W-1-8*k -: 8];
         end else if (pad_en_i && (7'(k) == idx_i)) begin
            block_o[BLOCK_W-1-8*k -: 8] = PAD_BYTE;
         end else if (len_en_i && (k >= LEN_OFFSET)) begin
            block_o[BLOCK_W-1-8*k -: 8] = len_i[8*(BLOCK_BYTES-1-k) +: 8];
         end
      end
   end

endmodule

// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs bytes big-endian into 512-bit blocks, appends
// 0x80/zeros/bit length, and hands blocks to the core with a tick/done handshake.
// Optional length-overflow detection (err_o) is enabled by SHA256_PADDER_OVF_CHECK_EN.
module sha256_padder
   import sha256_pkg::*;
#(
   parameter int LEN_W        = 64,
   parameter int DONE_TIMEOUT = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [7:0]         s_data_i,
   input  logic               s_valid_i,
   input  logic               s_last_i,
   input  logic               s_empty_i,
   output logic               s_ready_o,
   output logic [BLOCK_W-1:0] block_o,
   output logic               tick_o,
   output logic               final_o,
   input  logic               done_i,
   output logic               busy_o,
   output state_t             dbg_state_o
`ifdef SHA256_PADDER_OVF_CHECK_EN
   ,
   output logic               err_o
`endif
);

   // Handshake: a byte transfers on a rising clk edge where s_valid_i && s_ready_o;
   // a block is offered by a one-cycle tick_o and is held until done_i in WAIT.

   state_t               state_q, state_d;
   logic [BLOCK_W-1:0]   block_q, block_d;
   logic [6:0]           idx_q, idx_d;
   logic [LEN_W-1:0]     len_q, len_d;
   logic                 final_q, final_d;
   logic                 pend_q, pend_d;
   logic                 padded_q, padded_d;
   logic                 busy_q, busy_d;
   logic                 run_q;
   logic [31:0]          tmo_q, tmo_d;

   logic                 accept;
   logic                 drop;
   logic [LEN_W:0]       len_sum;
   logic [6:0]           pb_idx;
   logic                 pb_pad, pb_len;
   logic [BLOCK_W-1:0]   pb_out;

   assign accept  = s_valid_i && s_ready_o;
   assign len_sum = {1'b0, len_q} + (LEN_W+1)'(8);

`ifdef SHA256_PADDER_OVF_CHECK_EN
   logic err_q, err_d;
   // Once the counter would wrap, the rest of the message is swallowed.
   assign drop  = (busy_q && err_q) || len_sum[LEN_W];
   assign err_o = err_q;
`else
   assign drop  = 1'b0;
`endif

   sha256_pad_block u_pad (
      .block_i  (block_q),
      .idx_i    (pb_idx),
      .len_i    (64'(len_q)),
      .pad_en_i (pb_pad),
      .len_en_i (pb_len),
      .block_o  (pb_out)
   );

   always_comb begin
      state_d  = state_q;
      block_d  = block_q;
      idx_d    = idx_q;
      len_d    = len_q;
      final_d  = final_q;
      pend_d   = pend_q;
      padded_d = padded_q;
      busy_d   = busy_q;
      tmo_d    = tmo_q;
      pb_idx   = idx_q;
      pb_pad   = 1'b1;
      pb_len   = (idx_q <= 7'(LEN_OFFSET-1));
`ifdef SHA256_PADDER_OVF_CHECK_EN
      err_d    = err_q;
`endif
      case (state_q)
         ST_FILL: begin
            if (accept) begin
               busy_d = 1'b1;
`ifdef SHA256_PADDER_OVF_CHECK_EN
               err_d  = !s_empty_i && drop;
`endif
               if (!s_empty_i && !drop) begin
                  block_d[BLOCK_W-1-8*int'(idx_q) -: 8] = s_data_i;
                  idx_d = idx_q + 7'd1;
                  len_d = len_sum[LEN_W-1:0];
               end
               if (s_last_i) begin
                  state_d = ST_PAD;
               end else if (!s_empty_i && !drop && (idx_q == 7'(BLOCK_BYTES-1))) begin
                  state_d = ST_SEND;
                  final_d = 1'b0;
                  pend_d  = 1'b0;
               end
            end
         end
         ST_PAD: begin
            // idx 64 leaves the block untouched; marker and length move to LENBLK.
            block_d  = pb_out;
            final_d  = pb_len;
            pend_d   = !pb_len;
            padded_d = (idx_q < 7'(BLOCK_BYTES));
            state_d  = ST_SEND;
         end
         ST_LENBLK: begin
            pb_idx  = 7'd0;
            pb_pad  = !padded_q;
            pb_len  = 1'b1;
            block_d = pb_out;
            final_d = 1'b1;
            pend_d  = 1'b0;
            state_d = ST_SEND;
         end
         ST_SEND: begin
            tmo_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (done_i) begin
               if (pend_q) begin
                  state_d = ST_LENBLK;
               end else begin
                  state_d = ST_FILL;
                  idx_d   = '0;
                  if (final_q) begin
                     len_d  = '0;
                     busy_d = 1'b0;
                  end
               end
            end else if ((DONE_TIMEOUT != 0) && (tmo_q >= 32'(DONE_TIMEOUT))) begin
               state_d = ST_FILL;
               idx_d   = '0;
               len_d   = '0;
               busy_d  = 1'b0;
               pend_d  = 1'b0;
               final_d = 1'b0;
               block_d = '0;
            end else begin
               tmo_d = tmo_q + 32'd1;
            end
         end
         default: state_d = ST_FILL;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_FILL;
         block_q  <= '0;
         idx_q    <= '0;
         len_q    <= '0;
         final_q  <= 1'b0;
         pend_q   <= 1'b0;
         padded_q <= 1'b0;
         busy_q   <= 1'b0;
         run_q    <= 1'b0;
         tmo_q    <= '0;
      end else begin
         state_q  <= state_d;
         block_q  <= block_d;
         idx_q    <= idx_d;
         len_q    <= len_d;
         final_q  <= final_d;
         pend_q   <= pend_d;
         padded_q <= padded_d;
         busy_q   <= busy_d;
         run_q    <= 1'b1;
         tmo_q    <= tmo_d;
      end
   end

`ifdef SHA256_PADDER_OVF_CHECK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= err_d;
   end
`endif

   // run_q keeps s_ready low while reset is held even though state is FILL.
   assign s_ready_o   = run_q && (state_q == ST_FILL);
   assign tick_o      = (state_q == ST_SEND);
   assign final_o     = final_q;
   assign block_o     = block_q;
   assign busy_o      = busy_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sha256_padder.sv
// Directed bench for sha256_padder: a driver feeds messages, expected blocks
// are queued per message, and a monitor pops one entry per tick.
module tb_sha256_padder;
   import sha256_pkg::*;

   logic               clk = 1'b0;
   logic               rst;
   logic [7:0]         s_data_i;
   logic               s_valid_i, s_last_i, s_empty_i;
   logic               s_ready_o;
   logic [BLOCK_W-1:0] block_o;
   logic               tick_o, final_o, done_i, busy_o;
   state_t             dbg_state_o;

   int checks   = 0;
   int failures = 0;
   logic [BLOCK_W:0] exp_q[$];
   int done_delay = 2;
   bit no_done    = 1'b0;

   sha256_padder dut (
      .clk         (clk),
      .rst         (rst),
      .s_data_i    (s_data_i),
      .s_valid_i   (s_valid_i),
      .s_last_i    (s_last_i),
      .s_empty_i   (s_empty_i),
      .s_ready_o   (s_ready_o),
      .block_o     (block_o),
      .tick_o      (tick_o),
      .final_o     (final_o),
      .done_i      (done_i),
      .busy_o      (busy_o),
      .dbg_state_o (dbg_state_o)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_val("ready_after_rst", 64'(s_ready_o), 64'd1);
   endtask

   // driver
   task automatic send_byte(input logic [7:0] d, input logic last, input logic empty);
      int guard;
      guard = 0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      @(negedge clk);
      s_valid_i = 1'b1;
      s_data_i  = d;
      s_last_i  = last;
      s_empty_i = empty;
      while (!s_ready_o && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 1000) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout act=not_ready exp=ready");
      end
      @(posedge clk);
      #1;
      s_valid_i = 1'b0;
      s_last_i  = 1'b0;
      s_empty_i = 1'b0;
   endtask

   task automatic send_fill(input int n, input logic [7:0] val);
      for (int i = 0; i < n; i++) send_byte(val, (i == n - 1), 1'b0);
   endtask

   task automatic send_abc();
      send_byte(8'h61, 1'b0, 1'b0);
      send_byte(8'h62, 1'b0, 1'b0);
      send_byte(8'h63, 1'b1, 1'b0);
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy_o) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 3000) begin
         failures++;
         $display("FAIL %s_timeout act=pending=%0d busy=%0b exp=idle", name, exp_q.size(), busy_o);
      end
   endtask

   // core model: acknowledge each tick after done_delay cycles
   initial begin : responder
      done_i = 1'b0;
      forever begin
         @(negedge clk);
         if (tick_o && !rst && !no_done) begin
            repeat (done_delay + 1) @(negedge clk);
            done_i = 1'b1;
            @(negedge clk);
            done_i = 1'b0;
         end
      end
   end

   // scoreboard monitor
   logic [BLOCK_W:0] cap;
   logic [BLOCK_W:0] exp_v;
   bit in_wait  = 1'b0;
   bit wait_bad = 1'b0;
   initial begin : monitor
      forever begin
         @(posedge clk);
         #2;
         if (rst) begin
            in_wait = 1'b0;
         end else if (tick_o) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_tick act=final=%0b block=%h exp=no_tick", final_o, block_o);
            end else begin
               exp_v = exp_q.pop_front();
               if ({final_o, block_o} !== exp_v) begin
                  failures++;
                  $display("FAIL block act=%0b_%h exp=%0b_%h", final_o, block_o, exp_v[BLOCK_W], exp_v[BLOCK_W-1:0]);
               end
            end
            cap      = {final_o, block_o};
            wait_bad = 1'b0;
            in_wait  = 1'b1;
         end else if (in_wait) begin
            if (dbg_state_o == ST_WAIT) begin
               if ({final_o, block_o} !== cap || s_ready_o) wait_bad = 1'b1;
            end else begin
               checks++;
               if (wait_bad) begin
                  failures++;
                  $display("FAIL wait_hold act=changed_or_ready exp=stable_not_ready");
               end
               in_wait = 1'b0;
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      failures++;
      $display("FAIL watchdog act=running exp=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int n;
      rst       = 1'b1;
      s_data_i  = 8'h00;
      s_valid_i = 1'b0;
      s_last_i  = 1'b0;
      s_empty_i = 1'b0;
      repeat (3) @(negedge clk);
      check_val("rst_ready", 64'(s_ready_o), 64'd0);
      check_val("rst_tick",  64'(tick_o),    64'd0);
      check_val("rst_final", 64'(final_o),   64'd0);
      check_val("rst_busy",  64'(busy_o),    64'd0);
      check_val("rst_block", 64'(block_o != '0), 64'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_val("ready_first_edge", 64'(s_ready_o), 64'd1);

      // "abc"
      exp_q.push_back({1'b1, 32'h61626380, 416'h0, 64'h18});
      send_abc();
      check_val("busy_in_msg", 64'(busy_o), 64'd1);
      wait_idle("abc");

      // empty message
      exp_q.push_back({1'b1, 8'h80, 440'h0, 64'h0});
      send_byte(8'hEE, 1'b1, 1'b1);
      wait_idle("empty");
      check_val("busy_after_empty", 64'(busy_o), 64'd0);

      // 55 zero bytes: marker at byte 55, length fits
      exp_q.push_back({1'b1, 440'h0, 8'h80, 64'h1B8});
      send_fill(55, 8'h00);
      wait_idle("len55");

      // 56 zero bytes: marker in first block, length in a second block
      exp_q.push_back({1'b0, 448'h0, 8'h80, 56'h0});
      exp_q.push_back({1'b1, 448'h0, 64'h1C0});
      send_fill(56, 8'h00);
      wait_idle("len56");

      // 64 bytes: full data block, then marker + length block
      exp_q.push_back({1'b0, {64{8'hFF}}});
      exp_q.push_back({1'b1, 8'h80, 440'h0, 64'h200});
      send_fill(64, 8'hFF);
      wait_idle("len64");

      // slow core: block/final held, no ready, no extra tick
      done_delay = 100;
      exp_q.push_back({1'b1, 32'h61626380, 416'h0, 64'h18});
      send_abc();
      wait_idle("slow_done");
      done_delay = 2;

      // reset while waiting on the first block of a 56-byte message
      no_done = 1'b1;
      exp_q.push_back({1'b0, 448'h0, 8'h80, 56'h0});
      send_fill(56, 8'h00);
      n = 0;
      while (dbg_state_o != ST_WAIT && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_val("reached_wait", 64'(dbg_state_o == ST_WAIT), 64'd1);
      do_reset();
      no_done = 1'b0;
      repeat (30) @(negedge clk);
      check_val("no_lenblk_after_rst", 64'(exp_q.size()), 64'd0);
      check_val("busy_after_rst", 64'(busy_o), 64'd0);
      exp_q.push_back({1'b1, 32'h61626380, 416'h0, 64'h18});
      send_abc();
      wait_idle("abc_after_rst");

      repeat (5) @(negedge clk);
      check_val("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
